// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the handshake arbiter:
//   hs_state_t  - FSM state encoding (IDLE, SETUP, WAIT_HI, WAIT_LO, DONE)
//   RR_MAX_REQ  - widest request vector the round-robin helper supports
//   rr_pick()   - round-robin selection: one-hot winner from a request vector,
//                 searching from ptr+1 upwards with wrap at n.
// -----------------------------------------------------------------------------
package handshake_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } hs_state_t;

    localparam int unsigned RR_MAX_REQ = 32;

    // Returns a one-hot vector selecting the first set bit of req found when
    // scanning ptr+1, ptr+2, ... modulo n. Returns zero when no bit is set.
    // Only the low n bits of req are considered; ptr must be below n.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [4:0]            ptr,
        input logic [5:0]            n
    );
        logic [RR_MAX_REQ-1:0] pick;
        logic                  found;
        logic [5:0]            idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            if (k <= int'(n)) begin
                idx = {1'b0, ptr} + 6'(k);
                // ptr < n and k <= n, so a single subtraction is enough to wrap
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[4:0]]) begin
                    pick[idx[4:0]] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing a single asynchronous level into the clk
// domain. Both stages clear to 0 on reset.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   d_i  - asynchronous input level
//   q_o  - synchronized level, two clk edges behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/handshake_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_arbiter
// Round-robin arbiter sharing one four-phase (return-to-zero) bundled-data
// channel among n_req clocked requesters. A transaction presents the winner's
// data for one full cycle, raises ch_req, waits for the (synchronized)
// acknowledge to rise, drops ch_req, waits for acknowledge to fall, then pulses
// req_ready to the winner. A stuck-low acknowledge is aborted after
// timeout_cycles and reported through timeout_err alongside req_ready.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   req_valid    - per-requester request, held until its req_ready
//   req_data     - packed per-requester bundles, lane i at [i*data_width +: data_width]
//   req_ready    - one-cycle one-hot completion pulse to the served requester
//   grant        - one-hot channel owner, zero when idle
//   busy         - high whenever the FSM is not idle
//   timeout_err  - one-cycle pulse with req_ready when the transfer was aborted
//   ch_req       - channel request
//   ch_data      - channel data bundle
//   ch_ack       - channel acknowledge, asynchronous to clk
// -----------------------------------------------------------------------------
module handshake_arbiter
    import handshake_pkg::*;
#(
    parameter int n_req          = 4,
    parameter int data_width     = 8,
    parameter int timeout_cycles = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [n_req-1:0]            req_valid,
    input  logic [n_req*data_width-1:0] req_data,
    output logic [n_req-1:0]            req_ready,
    output logic [n_req-1:0]            grant,
    output logic                        busy,
    output logic                        timeout_err,
    output logic                        ch_req,
    output logic [data_width-1:0]       ch_data,
    input  logic                        ch_ack
);

    localparam int PTR_W = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(timeout_cycles);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(n_req - 1);

    // Registered state and outputs
    hs_state_t             state_q,       state_d;
    logic [n_req-1:0]      grant_q,       grant_d;
    logic [data_width-1:0] ch_data_q,     ch_data_d;
    logic                  ch_req_q,      ch_req_d;
    logic [n_req-1:0]      req_ready_q,   req_ready_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  busy_q,        busy_d;
    logic [PTR_W-1:0]      ptr_q,         ptr_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic                  err_q,         err_d;

    // Acknowledge is only ever observed through the synchronizer.
    logic ack_s;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ch_ack),
        .q_o (ack_s)
    );

    // Round-robin winner among the current requests
    logic [RR_MAX_REQ-1:0] pick_full;
    logic [n_req-1:0]      pick_oh;
    logic                  any_pick;

    assign pick_full = rr_pick(RR_MAX_REQ'(req_valid), 5'(ptr_q), 6'(n_req));
    assign pick_oh   = pick_full[n_req-1:0];
    assign any_pick  = |pick_full;

    // One-hot data mux: mask each lane with its pick bit, then OR the lanes.
    logic [data_width-1:0] lane_sel [n_req];
    logic [data_width-1:0] pick_data;

    genvar gi;
    generate
        for (gi = 0; gi < n_req; gi++) begin : g_lane
            assign lane_sel[gi] = req_data[gi*data_width +: data_width]
                                & {data_width{pick_oh[gi]}};
        end
    endgenerate

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < n_req; i++) begin
            pick_data = pick_data | lane_sel[i];
        end
    end

    // Index of the current owner; becomes the new round-robin pointer.
    logic [PTR_W-1:0] grant_idx;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < n_req; i++) begin
            if (grant_q[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ch_data_d     = ch_data_q;
        ch_req_d      = ch_req_q;
        req_ready_d   = '0;
        timeout_err_d = 1'b0;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                // A high acknowledge means the channel has not returned to
                // zero yet (e.g. after a reset mid-transfer): hold off.
                if (any_pick && !ack_s) begin
                    grant_d   = pick_oh;
                    ch_data_d = pick_data;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // Data has been stable for a full cycle; now raise request.
                ch_req_d = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (ack_s) begin
                    ch_req_d = 1'b0;
                    state_d  = WAIT_LO;
                end else if (cnt_q == CNT_MAX) begin
                    ch_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = WAIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                // Completion outputs are registered here so they are
                // visible exactly while the FSM sits in DONE.
                if (!ack_s) begin
                    req_ready_d   = grant_q;
                    timeout_err_d = err_q;
                    state_d       = DONE;
                end
            end
            DONE: begin
                ptr_d   = grant_idx;
                err_d   = 1'b0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d  = '0;
                ch_req_d = 1'b0;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            ch_data_q     <= '0;
            ch_req_q      <= 1'b0;
            req_ready_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            ptr_q         <= PTR_RESET;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ch_data_q     <= ch_data_d;
            ch_req_q      <= ch_req_d;
            req_ready_q   <= req_ready_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign ch_req      = ch_req_q;
    assign ch_data     = ch_data_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_arbiter
// Directed bench for handshake_arbiter (4 requesters, 8-bit data, timeout 5).
// The stimulus process queues expected transactions and direct checks; an
// independent monitor process pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_handshake_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 timeout_err;
    logic                 ch_req;
    logic [DW-1:0]        ch_data;
    logic                 ch_ack;

    always #5 clk = ~clk;

    handshake_arbiter #(
        .n_req          (NREQ),
        .data_width     (DW),
        .timeout_cycles (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .ch_req      (ch_req),
        .ch_data     (ch_data),
        .ch_ack      (ch_ack)
    );

    typedef struct {
        logic [NREQ-1:0] grant;
        logic [DW-1:0]   data;
        logic            terr;
    } txn_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    txn_t exp_q[$];
    chk_t chk_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic end_req = 1'b0;

    // ---------------- stimulus-side state (stimulus process only) ----------
    int          cyc = 0;
    logic        ack_auto;
    int          ack_delay;
    int          dcnt;
    int          rem [NREQ];
    logic [DW-1:0] next_data [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic expect_txn(input logic [NREQ-1:0] g, input logic [DW-1:0] d, input logic t);
        exp_q.push_back('{g, d, t});
    endtask

    // One clock: acknowledge model and requester behaviour, both at negedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (ack_auto) begin
            if (ch_ack !== ch_req) begin
                dcnt++;
                if (dcnt >= ack_delay) begin
                    ch_ack = ch_req;
                    dcnt   = 0;
                end
            end else begin
                dcnt = 0;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) req_valid[i] = 1'b0;
                else             req_data[i*DW +: DW] = next_data[i];
            end
        end
    endtask

    task automatic wait_ready(input string tag, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (req_ready == '0 && lat < 100);
        chk(tag, 32'(req_ready != '0), 32'd1);
    endtask

    task automatic wait_ch_req(input string tag, input logic lvl);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (ch_req !== lvl && n < 50);
        chk(tag, 32'(ch_req), 32'(lvl));
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (grant == '0 && n < 20);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        int          n;
        int          done;
        int          ngr;
        int          c1;
        int          c2;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] gprev;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        ch_ack    = 1'b0;
        ack_auto  = 1'b1;
        ack_delay = 2;
        dcnt      = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]       = 0;
            next_data[i] = '0;
        end

        // Reset values
        repeat (3) step();
        chk("rst_grant",       32'(grant),       32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_ch_req",      32'(ch_req),      32'd0);
        chk("rst_ch_data",     32'(ch_data),     32'd0);
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // A: single request on lane 2, ack model 2-cycle delay
        req_data[2*DW +: DW] = 8'hA5;
        rem[2]    = 1;
        req_valid = 4'b0100;
        expect_txn(4'b0100, 8'hA5, 1'b0);
        step();
        chk("a_grant",       32'(grant),   32'h4);
        chk("a_ch_data",     32'(ch_data), 32'hA5);
        chk("a_busy",        32'(busy),    32'd1);
        chk("a_ch_req_low",  32'(ch_req),  32'd0);
        wait_ready("a_ready_seen", lat);
        chk("a_latency", 32'(lat + 1), 32'd10);
        step();
        chk("a_idle_busy", 32'(busy), 32'd0);

        // E: reset while in WAIT_HI, channel acknowledge left high
        ack_auto = 1'b0;
        ch_ack   = 1'b0;
        req_data[3*DW +: DW] = 8'h3C;
        rem[3]    = 1;
        req_valid = 4'b1000;
        expect_txn(4'b1000, 8'h3C, 1'b0);
        wait_ch_req("e_ch_req_rise", 1'b1);
        step();
        chk("e_grant_before_rst", 32'(grant), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("e_async_ch_req", 32'(ch_req), 32'd0);
        chk("e_async_grant",  32'(grant),  32'd0);
        chk("e_async_busy",   32'(busy),   32'd0);
        exp_q.delete();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        ch_ack = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // Round-robin: all four requesting, lane 0 asks twice
        req_data     = {8'h44, 8'h33, 8'h22, 8'h11};
        next_data[0] = 8'h55;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        req_valid = 4'b1111;
        expect_txn(4'b0001, 8'h11, 1'b0);
        expect_txn(4'b0010, 8'h22, 1'b0);
        expect_txn(4'b0100, 8'h33, 1'b0);
        expect_txn(4'b1000, 8'h44, 1'b0);
        expect_txn(4'b0001, 8'h55, 1'b0);
        g = '0;
        repeat (6) begin
            step();
            g = g | grant;
        end
        chk("e_no_grant_ack_high", 32'(g), 32'd0);
        ch_ack    = 1'b0;
        dcnt      = 0;
        ack_delay = 1;
        ack_auto  = 1'b1;
        wait_grant(n);
        chk("e_regrant_latency", 32'(n), 32'd3);
        chk("e_ptr_restart",     32'(grant), 32'h1);
        c1 = cyc; c2 = 0; ngr = 1; done = 0; n = 0;
        gprev = grant;
        while (done < 5 && n < 400) begin
            step();
            n++;
            if (req_ready != '0) done++;
            if (grant != '0 && gprev == '0) begin
                ngr++;
                if (ngr == 2) c2 = cyc;
            end
            gprev = grant;
        end
        chk("rr_done_count",   32'(done),    32'd5);
        chk("rr_grant_period", 32'(c2 - c1), 32'd9);
        step();

        // D: acknowledge stuck high at idle with a request pending
        ack_auto = 1'b0;
        ch_ack   = 1'b1;
        repeat (3) step();
        req_data[1*DW +: DW] = 8'h7E;
        rem[1]    = 1;
        req_valid = 4'b0010;
        expect_txn(4'b0010, 8'h7E, 1'b0);
        g = '0;
        repeat (6) begin
            step();
            g = g | grant;
        end
        chk("d_no_grant_ack_high", 32'(g), 32'd0);
        ch_ack    = 1'b0;
        dcnt      = 0;
        ack_delay = 2;
        ack_auto  = 1'b1;
        wait_grant(n);
        chk("d_grant_latency", 32'(n), 32'd3);
        wait_ready("d_ready_seen", lat);
        step();

        // C: acknowledge never rises, transfer aborted by timeout
        ack_auto = 1'b0;
        ch_ack   = 1'b0;
        req_data[2*DW +: DW] = 8'hC3;
        rem[2]    = 1;
        req_valid = 4'b0100;
        expect_txn(4'b0100, 8'hC3, 1'b1);
        wait_ready("c_ready_seen", lat);
        chk("c_latency",     32'(lat),         32'd9);
        chk("c_timeout_err", 32'(timeout_err), 32'd1);
        step();

        // F: requester drops valid while the FSM waits for ack to fall
        dcnt      = 0;
        ack_delay = 2;
        ack_auto  = 1'b1;
        req_data[0*DW +: DW] = 8'h5A;
        rem[0]    = 1;
        req_valid = 4'b0001;
        expect_txn(4'b0001, 8'h5A, 1'b0);
        wait_ch_req("f_ch_req_rise", 1'b1);
        wait_ch_req("f_ch_req_fall", 1'b0);
        req_valid[0] = 1'b0;
        wait_ready("f_ready_seen", lat);
        chk("f_ready", 32'(req_ready), 32'h1);
        g = '0;
        repeat (15) begin
            step();
            g = g | grant;
        end
        chk("f_no_regrant", 32'(g),    32'd0);
        chk("f_idle_busy",  32'(busy), 32'd0);

        end_req = 1'b1;
        repeat (5) @(negedge clk);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mcmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        chk_t            c;
        txn_t            e;
        logic            req_prev;
        logic [NREQ-1:0] grant_prev;
        logic [DW-1:0]   data_prev;
        int              hi_run;
        int              mcyc;

        req_prev   = 1'b0;
        grant_prev = '0;
        data_prev  = '0;
        hi_run     = 0;
        mcyc       = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (mcyc > 50000) begin
                $display("FAIL watchdog: got %0d cycles, expected completion", mcyc);
                $fatal(1, "watchdog expired");
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                mcmp(c.name, c.act, c.exp);
            end
            if (!rst) begin
                if (ch_req && !req_prev) begin
                    hi_run = 0;
                    if (exp_q.size() == 0) begin
                        mcmp("unexpected_ch_req", 32'(ch_req), 32'd0);
                    end else begin
                        mcmp("txn_grant_at_req", 32'(grant),   32'(exp_q[0].grant));
                        mcmp("txn_data_at_req",  32'(ch_data), 32'(exp_q[0].data));
                        mcmp("setup_grant",      32'(grant_prev), 32'(grant));
                        mcmp("setup_data",       32'(data_prev),  32'(ch_data));
                    end
                end
                if (ch_req) hi_run++;
                if (!ch_req && req_prev && exp_q.size() > 0 && exp_q[0].terr) begin
                    mcmp("timeout_req_high_cycles", 32'(hi_run), 32'(TO + 1));
                end
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        mcmp("unexpected_req_ready", 32'(req_ready), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        mcmp("txn_req_ready",   32'(req_ready),   32'(e.grant));
                        mcmp("txn_timeout_err", 32'(timeout_err), 32'(e.terr));
                        mcmp("txn_grant_done",  32'(grant),       32'(e.grant));
                    end
                end else if (timeout_err) begin
                    mcmp("stray_timeout_err", 32'(timeout_err), 32'd0);
                end
            end
            req_prev   = ch_req;
            grant_prev = grant;
            data_prev  = ch_data;
            if (end_req) begin
                mcmp("pending_txns", 32'(exp_q.size()), 32'd0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

endmodule

// File: doc/handshake_arbiter.md
# handshake_arbiter

Synchronous round-robin arbiter that shares one asynchronous four-phase (return-to-zero) bundled-data channel between `n_req` clocked requesters. It drives the channel request line and data bundle, and waits on the channel acknowledge produced by the C-element completion detector. It sequences each transaction through both handshake phases and returns a one-cycle completion to the winning requester. It sits on the boundary between the clocked control domain and the self-timed datapath.

## Interface
- `n_req`, 4: number of requesters (≥2).
- `data_width`, 8: width of each requester's data bundle.
- `timeout_cycles`, 255: maximum cycles to wait for acknowledge rise before abort (≥1).

- `clk`  in  1  single system clock; all state updates on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  n_req  per-requester transaction request; held until own `req_ready`.
- `req_data`  in  n_req*data_width  packed bundles; requester i at bits [i*data_width +: data_width]; held stable with `req_valid`.
- `req_ready`  out  n_req  one-hot, one-cycle completion pulse to granted requester.
- `grant`  out  n_req  one-hot owner of channel; zero when idle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse, coincident with `req_ready`, when the transaction was aborted.
- `ch_req`  out  1  four-phase channel request.
- `ch_data`  out  data_width  channel data bundle.
- `ch_ack`  in  1  channel acknowledge; asynchronous to `clk`.

## Operation
- `ch_ack` passes through a 2-flop synchronizer (reset 0) → `ack_s`; FSM never uses raw `ch_ack`.
- All outputs registered (Moore). Reset values: `req_ready`=0, `grant`=0, `busy`=0, `timeout_err`=0, `ch_req`=0, `ch_data`=0. State = IDLE, RR pointer = n_req-1 (requester 0 highest priority first), timeout counter 0, error flag 0.
- States:
  - IDLE: if any `req_valid` and `ack_s`=0 → pick first valid index searching from pointer+1 with wrap. Register `grant` and `ch_data`. → SETUP. If `ack_s`=1, stay IDLE (channel not yet returned to zero).
  - SETUP: data bundle stable; `ch_req`=0. → WAIT_HI, setting `ch_req`=1. Clear counter.
  - WAIT_HI: `ack_s`=1 → `ch_req`=0, → WAIT_LO. Else counter++. On counter == `timeout_cycles`: `ch_req`=0, set error flag, → WAIT_LO.
  - WAIT_LO: `ack_s`=0 → DONE. No timeout.
  - DONE: `req_ready`=`grant` for this cycle; `timeout_err`=error flag. Pointer ← granted index. Clear error flag, `grant`=0. → IDLE.
- `ch_data` and `grant` constant from SETUP through DONE.
- Deasserting `req_valid` mid-transaction is ignored; the transaction completes.
- Counter width `$clog2(timeout_cycles+1)`; saturates at `timeout_cycles`, never wraps.
- Reset mid-transaction: `ch_req`, `grant`, and `busy` drop asynchronously. After release, IDLE blocks new grants until `ack_s`=0, which guarantees return-to-zero.

## Timing
- `req_valid` sampled in IDLE at edge k → `grant`/`ch_data` valid at k+1 → `ch_req` rises at k+2 (one full cycle of data setup before request).
- `ch_ack` rise to `ch_req` fall: 3 edges (2 sync + 1 FSM).
- `ch_ack` fall to `req_ready` pulse: 3 edges (2 sync + WAIT_LO→DONE), pulse at DONE.
- Ideal channel (ack follows req within one cycle): grant to grant for continuous requests is 9 cycles.
- Timeout: `ch_req` high exactly `timeout_cycles`+1 cycles before forced low.

## Structure
- `handshake_pkg`: state enum `hs_state_t` {IDLE, SETUP, WAIT_HI, WAIT_LO, DONE}; round-robin pick function (one-hot result from request vector and pointer).
- Sub-module `sync_2ff`: 2-flop synchronizer with async active-high reset to 0, used for `ch_ack`.

## Test plan
- Single request: `req_valid`=4'b0100, data 8'hA5, ack model 2-cycle delay. Expected: `grant`=4'b0100, `ch_data`=A5 one cycle before `ch_req`↑, one `req_ready`=4'b0100 pulse, `timeout_err`=0.
- Round-robin: all four valid continuously. Expected grant order 0,1,2,3,0; no requester granted twice before the others.
- Timeout: `ch_ack` tied 0, `timeout_cycles`=5. Expected: `ch_req` high 6 cycles, then `req_ready` and `timeout_err` pulse together.
- Stuck-high ack: `ch_ack`=1 at idle with request pending. Expected: no grant until `ch_ack`=0, then grant within 3 cycles.
- Reset in WAIT_HI. Expected: `ch_req`/`grant`/`busy` =0 without a clock edge. After release with `ch_ack` still 1, no grant until `ch_ack` falls. Pointer restarts at requester 0.
- Drop `req_valid` during WAIT_LO. Expected: transaction completes, `req_ready` still pulses once, no regrant.
